// File: rtl/uart_cmd_pkg.sv
// Shared types, ASCII constants and hex helpers for the UART command parser.
// Uppercase hex only: '0'-'9', 'A'-'F'.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN_REQ,
    DRAIN_CAP,
    PARSE,
    RESPOND
  } state_t;

  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_O  = 8'h4F;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46));
  endfunction

  // Only meaningful when is_hex(c) holds.
  function automatic logic [3:0] hex_to_nib(input logic [7:0] c);
    return c[3:0] + (c[6] ? 4'd9 : 4'd0);
  endfunction

  function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Sentence-based UART command parser: W<a><hh> writes, R<a> reads a register.
// Define UART_CMD_ECHO_EN to echo every drained byte to TX ahead of the reply.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN   = 16,
  parameter int REG_COUNT = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_fifo_empty,
  input  logic [7:0]             rx_fifo_data_out,
  input  logic                   rx_sentence_received,
  output logic                   rx_fifo_read_en,
  output logic [7:0]             tx_fifo_data_in,
  output logic                   tx_fifo_write_en,
  output logic [8*REG_COUNT-1:0] ctrl_regs,
  output logic                   busy,
  output logic [7:0]             cmd_count
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [4:0] RC = 5'(REG_COUNT);

  state_t        state;
  logic          pending;
  logic          overflow;
  logic [LW-1:0] len;
  logic [7:0]    sbuf [MAX_LEN];
  logic [7:0]    regs [REG_COUNT];
  logic [7:0]    rsp  [4];
  logic [1:0]    idx;
  logic [7:0]    cnt;

  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rval;
  logic       addr_ok;
  logic       w_ok;
  logic       r_ok;
  logic       keep;

  // Decode the stored sentence as a W or R command.
  always_comb begin
    addr    = hex_to_nib(sbuf[1]);
    wdata   = {hex_to_nib(sbuf[2]), hex_to_nib(sbuf[3])};
    rval    = regs[addr[AW-1:0]];
    addr_ok = is_hex(sbuf[1]) && ({1'b0, addr} < RC);
    w_ok    = !overflow && (len == LW'(4)) &&
              (sbuf[0] == CH_W) && addr_ok &&
              is_hex(sbuf[2]) && is_hex(sbuf[3]);
    r_ok    = !overflow && (len == LW'(2)) &&
              (sbuf[0] == CH_R) && addr_ok;
    keep    = (rx_fifo_data_out != CH_CR) &&
              (rx_fifo_data_out != CH_LF);
  end

  // Control FSM, sentence storage, register file and command counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= 1'b0;
      overflow <= 1'b0;
      len      <= '0;
      idx      <= '0;
      cnt      <= '0;
      rsp      <= '{CH_E, CH_R, CH_CR, CH_LF};
      for (int i = 0; i < REG_COUNT; i++)
        regs[i] <= '0;
    end else begin
      if (rx_sentence_received)
        pending <= 1'b1;
      unique case (state)
        IDLE: begin
          if (pending) begin
            pending  <= rx_sentence_received;
            len      <= '0;
            overflow <= 1'b0;
            state    <= DRAIN_REQ;
          end
        end
        DRAIN_REQ: begin
          state <= rx_fifo_empty ? PARSE : DRAIN_CAP;
        end
        DRAIN_CAP: begin
          state <= DRAIN_REQ;
          if (keep) begin
            if (len < LW'(MAX_LEN)) begin
              sbuf[len[IW-1:0]] <= rx_fifo_data_out;
              len <= len + LW'(1);
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        PARSE: begin
          idx <= '0;
          if ((len == '0) && !overflow) begin
            state <= IDLE;
          end else begin
            state <= RESPOND;
            if (w_ok) begin
              regs[addr[AW-1:0]] <= wdata;
              cnt <= cnt + 8'd1;
              rsp <= '{CH_O, CH_K, CH_CR, CH_LF};
            end else if (r_ok) begin
              cnt <= cnt + 8'd1;
              rsp <= '{nib_to_hex(rval[7:4]),
                       nib_to_hex(rval[3:0]),
                       CH_CR, CH_LF};
            end else begin
              rsp <= '{CH_E, CH_R, CH_CR, CH_LF};
            end
          end
        end
        RESPOND: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decoded from state; reset silences them in the same cycle.
  always_comb begin
    busy             = 1'b0;
    rx_fifo_read_en  = 1'b0;
    tx_fifo_write_en = 1'b0;
    tx_fifo_data_in  = 8'h00;
    if (!reset) begin
      busy            = (state != IDLE);
      rx_fifo_read_en = (state == DRAIN_REQ) && !rx_fifo_empty;
      if (state == RESPOND) begin
        tx_fifo_write_en = 1'b1;
        tx_fifo_data_in  = rsp[idx];
      end
`ifdef UART_CMD_ECHO_EN
      if (state == DRAIN_CAP) begin
        tx_fifo_write_en = 1'b1;
        tx_fifo_data_in  = rx_fifo_data_out;
      end
`endif
    end
  end

  // Flatten the register file onto the output bus.
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++)
      ctrl_regs[8*i +: 8] = regs[i];
  end

  assign cmd_count = cnt;

endmodule
